// File: rtl/arbitro_salida_pkg.sv
// Shared definitions for the output arbiter: FSM states, source count,
// counter width and a one-hot to index helper.
package arbitro_pkg;

  localparam int NUM_IN = 4;
  localparam int CNT_W  = 5;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_PAUSE  = 2'd3
  } state_t;

  function automatic logic [1:0] onehot_to_idx(input logic [NUM_IN-1:0] onehot);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (onehot[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/arbitro_salida_if.sv
// Bundle of upstream FIFO heads/flags, downstream push port and status
// outputs of the output arbiter.
interface arbitro_salida_if #(
  parameter int DATA_SIZE = 12
);
  import arbitro_pkg::*;

  logic [DATA_SIZE-1:0] data_in0;
  logic [DATA_SIZE-1:0] data_in1;
  logic [DATA_SIZE-1:0] data_in2;
  logic [DATA_SIZE-1:0] data_in3;
  logic                 fifo_empty0;
  logic                 fifo_empty1;
  logic                 fifo_empty2;
  logic                 fifo_empty3;
  logic                 fifo_af_out;
  logic                 pop0;
  logic                 pop1;
  logic                 pop2;
  logic                 pop3;
  logic                 push_out;
  logic [DATA_SIZE-1:0] data_out;
  logic [CNT_W-1:0]     cont0;
  logic [CNT_W-1:0]     cont1;
  logic [CNT_W-1:0]     cont2;
  logic [CNT_W-1:0]     cont3;
  logic                 idle;

  modport slave (
    input  data_in0, data_in1, data_in2, data_in3,
    input  fifo_empty0, fifo_empty1, fifo_empty2, fifo_empty3,
    input  fifo_af_out,
    output pop0, pop1, pop2, pop3,
    output push_out, data_out,
    output cont0, cont1, cont2, cont3,
    output idle
  );

  modport master (
    output data_in0, data_in1, data_in2, data_in3,
    output fifo_empty0, fifo_empty1, fifo_empty2, fifo_empty3,
    output fifo_af_out,
    input  pop0, pop1, pop2, pop3,
    input  push_out, data_out,
    input  cont0, cont1, cont2, cont3,
    input  idle
  );

endinterface

// File: rtl/arbitro_salida_rr_grant4.sv
// Four-way round-robin picker: the position right after the previous
// winner has highest priority, wrapping around.
module rr_grant4 (
  input  logic [3:0] request,
  input  logic [1:0] last_grant,
  output logic [3:0] grant
);

  // Scan the four positions starting after last_grant; first requester wins
  always_comb begin
    logic [1:0] idx;
    logic       found;
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= 4; i++) begin
      idx = last_grant + 2'(i);
      if (!found && request[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arbitro_salida.sv
// Output arbiter: pops four upstream FIFOs in round-robin order and forwards
// each word to one downstream FIFO, honouring its almost-full flag.
// The upstream FIFOs present a popped word one cycle after the pop, so the
// push happens in that cycle straight from the selected data_in port; the
// in-flight flag and its source index are the registered state behind it.
module arbitro_salida #(
  parameter int DATA_SIZE = 12,
  parameter int NUM_IN    = arbitro_pkg::NUM_IN
) (
  input logic            clk,
  input logic            reset,
  arbitro_salida_if.slave bus
);
  import arbitro_pkg::*;

  state_t               state;
  logic                 in_flight;
  logic [1:0]           last_grant;
  logic [NUM_IN-1:0]    request;
  logic [NUM_IN-1:0]    grant;
  logic [NUM_IN-1:0]    pop;
  logic                 any_req;
  logic                 pop_enable;
  logic [DATA_SIZE-1:0] data_arr [NUM_IN];
  logic [CNT_W-1:0]     cont [NUM_IN];

  assign data_arr[0] = bus.data_in0;
  assign data_arr[1] = bus.data_in1;
  assign data_arr[2] = bus.data_in2;
  assign data_arr[3] = bus.data_in3;

  assign request = ~{bus.fifo_empty3, bus.fifo_empty2, bus.fifo_empty1, bus.fifo_empty0};
  assign any_req = |request;

  rr_grant4 u_rr_grant4 (
    .request    (request),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Pops only while actively forwarding and the downstream FIFO has room;
  // the grant already skips any input that is empty this very cycle.
  assign pop_enable = (state == ST_ACTIVE) && !bus.fifo_af_out;
  assign pop        = pop_enable ? grant : '0;

  assign bus.pop0 = pop[0];
  assign bus.pop1 = pop[1];
  assign bus.pop2 = pop[2];
  assign bus.pop3 = pop[3];

  // last_grant always names the source of the word in flight
  assign bus.push_out = in_flight;
  assign bus.data_out = in_flight ? data_arr[last_grant] : '0;

  assign bus.cont0 = cont[0];
  assign bus.cont1 = cont[1];
  assign bus.cont2 = cont[2];
  assign bus.cont3 = cont[3];

  assign bus.idle = (state == ST_IDLE) && !in_flight;

  // Control FSM plus in-flight tracking, rotation pointer and per-source counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_RESET;
      in_flight  <= 1'b0;
      last_grant <= 2'd3;
      for (int i = 0; i < NUM_IN; i++) cont[i] <= '0;
    end else begin
      in_flight <= |pop;
      if (|pop) last_grant <= onehot_to_idx(pop);
      if (in_flight) cont[last_grant] <= cont[last_grant] + 1'b1;
      case (state)
        ST_RESET:  state <= ST_IDLE;
        ST_IDLE:   if (any_req && !bus.fifo_af_out) state <= ST_ACTIVE;
        // With every input empty nothing is popped, so a word pushed this
        // cycle is the last one and no word remains in flight afterwards.
        ST_ACTIVE: begin
          if (bus.fifo_af_out)  state <= ST_PAUSE;
          else if (!any_req)    state <= ST_IDLE;
        end
        ST_PAUSE:  if (!bus.fifo_af_out) state <= any_req ? ST_ACTIVE : ST_IDLE;
        default:   state <= ST_RESET;
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_salida.sv
// Directed testbench for arbitro_salida with a small model of four upstream
// FIFOs whose popped word appears on data_in one cycle after the pop.
module tb_arbitro_salida;
  import arbitro_pkg::*;

  localparam int DW = 12;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  arbitro_salida_if #(.DATA_SIZE(DW)) bus ();

  arbitro_salida #(.DATA_SIZE(DW), .NUM_IN(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [DW-1:0] mem [4][64];
  int            wr_ptr [4];
  int            rd_ptr [4];
  logic [DW-1:0] head [4];
  logic [3:0]    pop_vec;
  logic [19:0]   cont_all;

  assign pop_vec  = {bus.pop3, bus.pop2, bus.pop1, bus.pop0};
  assign cont_all = {bus.cont3, bus.cont2, bus.cont1, bus.cont0};

  assign bus.data_in0    = head[0];
  assign bus.data_in1    = head[1];
  assign bus.data_in2    = head[2];
  assign bus.data_in3    = head[3];
  assign bus.fifo_empty0 = (wr_ptr[0] == rd_ptr[0]);
  assign bus.fifo_empty1 = (wr_ptr[1] == rd_ptr[1]);
  assign bus.fifo_empty2 = (wr_ptr[2] == rd_ptr[2]);
  assign bus.fifo_empty3 = (wr_ptr[3] == rd_ptr[3]);

  // Upstream FIFO model: a pop moves the head word onto data_in at the edge
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (pop_vec[i] && (wr_ptr[i] != rd_ptr[i])) begin
        head[i]   <= mem[i][rd_ptr[i] % 64];
        rd_ptr[i] <= rd_ptr[i] + 1;
      end
    end
  end

  logic [DW-1:0] push_q [$];
  int            push_cyc [$];
  int            cyc = 0;

  // Log every pushed word with the cycle it appeared in
  always @(negedge clk) begin
    cyc++;
    if (!reset && bus.push_out) begin
      push_q.push_back(bus.data_out);
      push_cyc.push_back(cyc);
    end
  end

  // Guard against any hang
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic load_word(input int src, input logic [DW-1:0] value);
    mem[src][wr_ptr[src] % 64] = value;
    wr_ptr[src] = wr_ptr[src] + 1;
  endtask

  task automatic flush_fifos();
    for (int i = 0; i < 4; i++) wr_ptr[i] = rd_ptr[i];
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1;
    bus.fifo_af_out = 1'b0;
    flush_fifos();
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic wait_idle(input int max_cycles, input string tag);
    int n = 0;
    tick();
    while (!bus.idle && n < max_cycles) begin
      tick();
      n++;
    end
    checks++;
    if (bus.idle !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s_timeout: idle=%b, expected 1 within %0d cycles", tag, bus.idle, max_cycles);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.fifo_af_out = 1'b0;
    tick();
    tick();
    checks++;
    if (pop_vec !== 4'b0000) begin errors++; $display("[TB] FAIL reset_pop: got %b expected 0000", pop_vec); end
    checks++;
    if (bus.push_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_push: got %b expected 0", bus.push_out); end
    checks++;
    if (bus.data_out !== 12'h000) begin errors++; $display("[TB] FAIL reset_data: got %h expected 000", bus.data_out); end
    checks++;
    if (cont_all !== 20'h0) begin errors++; $display("[TB] FAIL reset_cont: got %h expected 00000", cont_all); end
    checks++;
    if (bus.idle !== 1'b0) begin errors++; $display("[TB] FAIL reset_idle: got %b expected 0", bus.idle); end
    reset = 1'b0;
    tick();
    checks++;
    if (bus.idle !== 1'b1) begin errors++; $display("[TB] FAIL reset_idle_after: got %b expected 1", bus.idle); end
  endtask

  task automatic test_single_source();
    logic [3:0]    exp_pop [5];
    logic          exp_push [5];
    logic [DW-1:0] exp_data [5];
    logic          exp_idle [5];
    exp_pop  = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
    exp_push = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_data = '{12'h000, 12'h001, 12'h002, 12'h003, 12'h000};
    exp_idle = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    checks++;
    if (bus.idle !== 1'b1) begin errors++; $display("[TB] FAIL single_idle_start: got %b expected 1", bus.idle); end
    load_word(0, 12'h001);
    load_word(0, 12'h002);
    load_word(0, 12'h003);
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (pop_vec !== exp_pop[k]) begin errors++; $display("[TB] FAIL single_pop[%0d]: got %b expected %b", k, pop_vec, exp_pop[k]); end
      checks++;
      if (bus.push_out !== exp_push[k]) begin errors++; $display("[TB] FAIL single_push[%0d]: got %b expected %b", k, bus.push_out, exp_push[k]); end
      if (exp_push[k]) begin
        checks++;
        if (bus.data_out !== exp_data[k]) begin errors++; $display("[TB] FAIL single_data[%0d]: got %h expected %h", k, bus.data_out, exp_data[k]); end
      end
      checks++;
      if (bus.idle !== exp_idle[k]) begin errors++; $display("[TB] FAIL single_idle[%0d]: got %b expected %b", k, bus.idle, exp_idle[k]); end
    end
    checks++;
    if (cont_all !== {5'd0, 5'd0, 5'd0, 5'd3}) begin errors++; $display("[TB] FAIL single_cont: got %h expected %h", cont_all, {5'd0, 5'd0, 5'd0, 5'd3}); end
  endtask

  task automatic test_round_robin();
    logic [DW-1:0] exp_data [8];
    logic [DW-1:0] got;
    int            base;
    exp_data = '{12'h001, 12'h501, 12'hA01, 12'hF01, 12'h002, 12'h502, 12'hA02, 12'hF02};
    do_reset();
    base = push_q.size();
    for (int w = 0; w < 2; w++) begin
      load_word(0, 12'h001 + 12'(w));
      load_word(1, 12'h501 + 12'(w));
      load_word(2, 12'hA01 + 12'(w));
      load_word(3, 12'hF01 + 12'(w));
    end
    wait_idle(40, "rr");
    checks++;
    if (push_q.size() - base !== 8) begin errors++; $display("[TB] FAIL rr_count: got %0d pushes expected 8", push_q.size() - base); end
    for (int k = 0; k < 8; k++) begin
      got = (base + k < push_q.size()) ? push_q[base + k] : 'x;
      checks++;
      if (got !== exp_data[k]) begin errors++; $display("[TB] FAIL rr_order[%0d]: got %h expected %h", k, got, exp_data[k]); end
    end
    for (int k = 1; k < 8; k++) begin
      if (base + k < push_cyc.size()) begin
        checks++;
        if (push_cyc[base + k] - push_cyc[base + k - 1] !== 1) begin
          errors++;
          $display("[TB] FAIL rr_back_to_back[%0d]: gap %0d cycles expected 1", k, push_cyc[base + k] - push_cyc[base + k - 1]);
        end
      end
    end
    checks++;
    if (cont_all !== {5'd2, 5'd2, 5'd2, 5'd2}) begin errors++; $display("[TB] FAIL rr_cont: got %h expected %h", cont_all, {5'd2, 5'd2, 5'd2, 5'd2}); end
  endtask

  task automatic test_backpressure();
    logic          af [12];
    logic [3:0]    exp_pop [12];
    logic          exp_push [12];
    logic [DW-1:0] exp_data [12];
    af       = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_pop  = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                 4'b0000, 4'b0100, 4'b0001, 4'b0010, 4'b0000, 4'b0000};
    exp_push = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_data = '{12'h000, 12'h010, 12'h110, 12'h000, 12'h000, 12'h000,
                 12'h000, 12'h000, 12'h210, 12'h020, 12'h120, 12'h000};
    do_reset();
    load_word(0, 12'h010);
    load_word(0, 12'h020);
    load_word(1, 12'h110);
    load_word(1, 12'h120);
    load_word(2, 12'h210);
    for (int k = 0; k < 12; k++) begin
      tick();
      bus.fifo_af_out = af[k];
      #1;
      checks++;
      if (pop_vec !== exp_pop[k]) begin errors++; $display("[TB] FAIL bp_pop[%0d]: got %b expected %b", k, pop_vec, exp_pop[k]); end
      checks++;
      if (bus.push_out !== exp_push[k]) begin errors++; $display("[TB] FAIL bp_push[%0d]: got %b expected %b", k, bus.push_out, exp_push[k]); end
      if (exp_push[k]) begin
        checks++;
        if (bus.data_out !== exp_data[k]) begin errors++; $display("[TB] FAIL bp_data[%0d]: got %h expected %h", k, bus.data_out, exp_data[k]); end
      end
    end
    checks++;
    if (bus.idle !== 1'b1) begin errors++; $display("[TB] FAIL bp_idle: got %b expected 1", bus.idle); end
    checks++;
    if (cont_all !== {5'd0, 5'd1, 5'd2, 5'd2}) begin errors++; $display("[TB] FAIL bp_cont: got %h expected %h", cont_all, {5'd0, 5'd1, 5'd2, 5'd2}); end
  endtask

  task automatic test_skip_empty();
    logic          flush1 [5];
    logic [3:0]    exp_pop [5];
    logic          exp_push [5];
    logic [DW-1:0] exp_data [5];
    flush1   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_pop  = '{4'b0001, 4'b0100, 4'b0001, 4'b0000, 4'b0000};
    exp_push = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_data = '{12'h000, 12'h0A1, 12'h2A1, 12'h0A2, 12'h000};
    do_reset();
    load_word(0, 12'h0A1);
    load_word(0, 12'h0A2);
    load_word(1, 12'h1A1);
    load_word(2, 12'h2A1);
    for (int k = 0; k < 5; k++) begin
      tick();
      if (flush1[k]) wr_ptr[1] = rd_ptr[1];
      #1;
      checks++;
      if (pop_vec !== exp_pop[k]) begin errors++; $display("[TB] FAIL skip_pop[%0d]: got %b expected %b", k, pop_vec, exp_pop[k]); end
      checks++;
      if (bus.push_out !== exp_push[k]) begin errors++; $display("[TB] FAIL skip_push[%0d]: got %b expected %b", k, bus.push_out, exp_push[k]); end
      if (exp_push[k]) begin
        checks++;
        if (bus.data_out !== exp_data[k]) begin errors++; $display("[TB] FAIL skip_data[%0d]: got %h expected %h", k, bus.data_out, exp_data[k]); end
      end
    end
    checks++;
    if (bus.idle !== 1'b1) begin errors++; $display("[TB] FAIL skip_idle: got %b expected 1", bus.idle); end
    checks++;
    if (cont_all !== {5'd0, 5'd1, 5'd0, 5'd2}) begin errors++; $display("[TB] FAIL skip_cont: got %h expected %h", cont_all, {5'd0, 5'd1, 5'd0, 5'd2}); end
  endtask

  task automatic test_counter_wrap();
    int base;
    do_reset();
    base = push_q.size();
    for (int k = 0; k < 33; k++) load_word(2, 12'h200 + 12'(k));
    wait_idle(80, "wrap");
    checks++;
    if (push_q.size() - base !== 33) begin errors++; $display("[TB] FAIL wrap_count: got %0d pushes expected 33", push_q.size() - base); end
    if (push_q.size() > base) begin
      checks++;
      if (push_q[push_q.size() - 1] !== 12'h220) begin errors++; $display("[TB] FAIL wrap_last: got %h expected 220", push_q[push_q.size() - 1]); end
    end
    checks++;
    if (cont_all !== {5'd0, 5'd1, 5'd0, 5'd0}) begin errors++; $display("[TB] FAIL wrap_cont: got %h expected %h", cont_all, {5'd0, 5'd1, 5'd0, 5'd0}); end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    load_word(0, 12'h0C1);
    load_word(0, 12'h0C2);
    load_word(0, 12'h0C3);
    tick();
    tick();
    tick();
    checks++;
    if (bus.push_out !== 1'b1 || bus.data_out !== 12'h0C2) begin
      errors++; $display("[TB] FAIL mid_inflight: push=%b data=%h expected 1/0c2", bus.push_out, bus.data_out);
    end
    checks++;
    if (bus.cont0 !== 5'd1) begin errors++; $display("[TB] FAIL mid_cont_before: got %0d expected 1", bus.cont0); end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.push_out !== 1'b0) begin errors++; $display("[TB] FAIL mid_push: got %b expected 0", bus.push_out); end
    checks++;
    if (pop_vec !== 4'b0000) begin errors++; $display("[TB] FAIL mid_pop: got %b expected 0000", pop_vec); end
    checks++;
    if (bus.data_out !== 12'h000) begin errors++; $display("[TB] FAIL mid_data: got %h expected 000", bus.data_out); end
    checks++;
    if (cont_all !== 20'h0) begin errors++; $display("[TB] FAIL mid_cont: got %h expected 00000", cont_all); end
    checks++;
    if (bus.idle !== 1'b0) begin errors++; $display("[TB] FAIL mid_idle: got %b expected 0", bus.idle); end
    tick();
    tick();
    checks++;
    if (bus.push_out !== 1'b0 || pop_vec !== 4'b0000) begin
      errors++; $display("[TB] FAIL mid_hold: push=%b pop=%b expected 0/0000", bus.push_out, pop_vec);
    end
    flush_fifos();
    load_word(0, 12'h0D1);
    load_word(1, 12'h1D1);
    reset = 1'b0;
    tick();
    checks++;
    if (pop_vec !== 4'b0000 || bus.idle !== 1'b1) begin
      errors++; $display("[TB] FAIL mid_restart_idle: pop=%b idle=%b expected 0000/1", pop_vec, bus.idle);
    end
    tick();
    checks++;
    if (pop_vec !== 4'b0001) begin errors++; $display("[TB] FAIL mid_first_grant: got %b expected 0001", pop_vec); end
    tick();
    checks++;
    if (bus.push_out !== 1'b1 || bus.data_out !== 12'h0D1) begin
      errors++; $display("[TB] FAIL mid_first_push: push=%b data=%h expected 1/0d1", bus.push_out, bus.data_out);
    end
    wait_idle(20, "mid");
    checks++;
    if (cont_all !== {5'd0, 5'd0, 5'd1, 5'd1}) begin errors++; $display("[TB] FAIL mid_cont_after: got %h expected %h", cont_all, {5'd0, 5'd0, 5'd1, 5'd1}); end
  endtask

  // Run every scenario in order, then report
  initial begin
    $display("[TB] starting arbitro_salida tests");
    test_reset();
    test_single_source();
    test_round_robin();
    test_backpressure();
    test_skip_empty();
    test_counter_wrap();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
